// File: rtl/wb_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wb_counter_pkg                                         |
// | Description : Shared definitions for the Wishbone counter responder: |
// |               register offsets, CTRL/STATUS bit indices, bus FSM     |
// |               states, reset constants and a byte-lane mask helper.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package wb_counter_pkg;

  // Register byte offsets inside the 256-byte window
  localparam logic [7:0] C_OFF_CTRL   = 8'h00;
  localparam logic [7:0] C_OFF_COUNT  = 8'h04;
  localparam logic [7:0] C_OFF_LIMIT  = 8'h08;
  localparam logic [7:0] C_OFF_STATUS = 8'h0C;
  localparam logic [7:0] C_OFF_IO_OUT = 8'h10;
  localparam logic [7:0] C_OFF_IO_OEB = 8'h14;

  // CTRL / STATUS bit positions
  localparam int C_CTRL_EN     = 0;
  localparam int C_CTRL_DOWN   = 1;
  localparam int C_CTRL_IRQ_EN = 2;
  localparam int C_STATUS_HIT  = 0;

  // Bus-side state machine
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_state_e;

  // Reset values
  localparam logic [2:0]  C_CTRL_RST   = 3'b000;
  localparam logic [15:0] C_IO_OUT_RST = 16'h0000;
  localparam logic [15:0] C_IO_OEB_RST = 16'hFFFF;

  // Expand the four byte enables into a 32-bit bit mask
  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    logic [31:0] mask;
    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return mask;
  endfunction

endpackage : wb_counter_pkg
`default_nettype wire

// File: rtl/wb_counter_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wb_counter_core                                        |
// | Description : Up/down counter with terminal limit compare and sticky |
// |               hit flag.                                              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   en, down     count enable and direction (1 = down)
//   limit        terminal value for up-count / reload value for down-count
//   load         bus write to COUNT this cycle, load_val is the new value
//   hit_clr      write-1-to-clear of the hit flag
//   count        current counter value
//   hit          sticky hit flag
//   hit_next     value hit will take at the next edge (for the irq flop)
module wb_counter_core
  import wb_counter_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             down,
  input  logic [CNT_W-1:0] limit,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             hit_clr,
  output logic [CNT_W-1:0] count,
  output logic             hit,
  output logic             hit_next
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q, count_d;
  logic             hit_q, hit_d;
  logic             wrap;

  always_comb begin
    count_d = count_q;
    hit_d   = hit_q;
    wrap    = down ? (count_q == '0) : (count_q == limit);

    // Clear first so that a wrap in the same cycle re-sets the flag
    if (hit_clr) begin
      hit_d = 1'b0;
    end

    // A bus load replaces the whole update, including its hit event
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (wrap) begin
        count_d = down ? limit : '0;
        hit_d   = 1'b1;
      end else begin
        count_d = down ? (count_q - C_ONE) : (count_q + C_ONE);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      hit_q   <= hit_d;
    end
  end

  assign count    = count_q;
  assign hit      = hit_q;
  assign hit_next = hit_d;

endmodule : wb_counter_core
`default_nettype wire

// File: rtl/wb_counter_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wb_counter_responder                                   |
// | Description : Wishbone classic slave with a programmable counter,    |
// |               sticky hit/interrupt and a 16-bit GPIO drive register. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
// Ports:
//   wb_clk_i, wb_rst_i   clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i Wishbone request qualifiers
//   wbs_sel_i            byte enables
//   wbs_adr_i/dat_i      byte address and write data
//   wbs_ack_o            single-cycle acknowledge
//   wbs_dat_o            read data, zero except during a read ack
//   io_out, io_oeb       GPIO drive value and output-enable bar
//   irq_o                registered STATUS.hit & CTRL.irq_en
module wb_counter_responder
  import wb_counter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          WAIT_STATES = 1,
  parameter int          CNT_W       = 32
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] io_out,
  output logic [15:0] io_oeb,
  output logic        irq_o
);

  // Wait counter is loaded with WAIT_STATES-1 and counts down to zero
  localparam logic [3:0] C_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit         C_NO_WAIT   = (WAIT_STATES == 0);

  wb_state_e        state_q, state_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [5:0]       adr_q, adr_d;          // word offset within window
  logic             we_q, we_d;
  logic [31:0]      dat_q, dat_d;
  logic [3:0]       sel_q, sel_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [15:0]      io_out_q, io_out_d;
  logic [15:0]      io_oeb_q, io_oeb_d;
  logic             irq_q, irq_d;

  logic             req;
  logic             commit;
  logic [31:0]      wmask;
  logic             count_load;
  logic [CNT_W-1:0] count_wdata;
  logic             hit_clr;
  logic [CNT_W-1:0] count_val;
  logic             hit;
  logic             hit_next;
  logic [31:0]      rdata;
  logic             unused_adr_lsb;

  // Byte lanes below word granularity carry no information here
  assign unused_adr_lsb = ^wbs_adr_i[1:0];

  assign req    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign commit = (state_q == ACK) & we_q;
  assign wmask  = sel_to_mask(sel_q);

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    adr_d      = adr_q;
    we_d       = we_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          adr_d = wbs_adr_i[7:2];
          we_d  = wbs_we_i;
          dat_d = wbs_dat_i;
          sel_d = wbs_sel_i;
          if (C_NO_WAIT) begin
            state_d = ACK;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = C_WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        // Master abandoned the cycle: drop it without ack or commit
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (wait_cnt_q == 4'd0) begin
          state_d = ACK;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------ register file
  assign count_wdata = (count_val & ~wmask[CNT_W-1:0]) | (dat_q[CNT_W-1:0] & wmask[CNT_W-1:0]);

  always_comb begin
    ctrl_d     = ctrl_q;
    limit_d    = limit_q;
    io_out_d   = io_out_q;
    io_oeb_d   = io_oeb_q;
    count_load = 1'b0;
    hit_clr    = 1'b0;
    if (commit) begin
      case (adr_q)
        C_OFF_CTRL[7:2]: begin
          if (sel_q[0]) begin
            ctrl_d = dat_q[2:0];
          end
        end
        C_OFF_COUNT[7:2]: begin
          count_load = 1'b1;
        end
        C_OFF_LIMIT[7:2]: begin
          limit_d = (limit_q & ~wmask[CNT_W-1:0]) | (dat_q[CNT_W-1:0] & wmask[CNT_W-1:0]);
        end
        C_OFF_STATUS[7:2]: begin
          hit_clr = sel_q[0] & dat_q[C_STATUS_HIT];
        end
        C_OFF_IO_OUT[7:2]: begin
          io_out_d = (io_out_q & ~wmask[15:0]) | (dat_q[15:0] & wmask[15:0]);
        end
        C_OFF_IO_OEB[7:2]: begin
          io_oeb_d = (io_oeb_q & ~wmask[15:0]) | (dat_q[15:0] & wmask[15:0]);
        end
        default: begin
        end
      endcase
    end
    irq_d = hit_next & ctrl_d[C_CTRL_IRQ_EN];
  end

  // ---------------------------------------------------------- read mux
  always_comb begin
    rdata = 32'h0;
    if ((state_q == ACK) && !we_q) begin
      case (adr_q)
        C_OFF_CTRL[7:2]:   rdata = {29'h0, ctrl_q};
        C_OFF_COUNT[7:2]:  rdata = 32'(count_val);
        C_OFF_LIMIT[7:2]:  rdata = 32'(limit_q);
        C_OFF_STATUS[7:2]: rdata = {31'h0, hit};
        C_OFF_IO_OUT[7:2]: rdata = {16'h0, io_out_q};
        C_OFF_IO_OEB[7:2]: rdata = {16'h0, io_oeb_q};
        default:           rdata = 32'h0;
      endcase
    end
  end

  // --------------------------------------------------------- registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      adr_q      <= 6'd0;
      we_q       <= 1'b0;
      dat_q      <= 32'h0;
      sel_q      <= 4'h0;
      ctrl_q     <= C_CTRL_RST;
      limit_q    <= '1;
      io_out_q   <= C_IO_OUT_RST;
      io_oeb_q   <= C_IO_OEB_RST;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      adr_q      <= adr_d;
      we_q       <= we_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      ctrl_q     <= ctrl_d;
      limit_q    <= limit_d;
      io_out_q   <= io_out_d;
      io_oeb_q   <= io_oeb_d;
      irq_q      <= irq_d;
    end
  end

  wb_counter_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .en       (ctrl_q[C_CTRL_EN]),
    .down     (ctrl_q[C_CTRL_DOWN]),
    .limit    (limit_q),
    .load     (count_load),
    .load_val (count_wdata),
    .hit_clr  (hit_clr),
    .count    (count_val),
    .hit      (hit),
    .hit_next (hit_next)
  );

  assign wbs_ack_o = (state_q == ACK);
  assign wbs_dat_o = rdata;
  assign io_out    = io_out_q;
  assign io_oeb    = io_oeb_q;
  assign irq_o     = irq_q;

endmodule : wb_counter_responder
`default_nettype wire

// File: tb/tb_wb_counter_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_wb_counter_responder                                |
// | Description : Directed self-checking bench for wb_counter_responder. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_wb_counter_responder;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic [15:0] io_out, io_oeb;
  logic        irq;

  logic        cyc3, stb3, we3;
  logic [3:0]  sel3;
  logic [31:0] adr3, dat3_i;
  logic        ack3;
  logic [31:0] dat3_o;
  logic [15:0] io_out3, io_oeb3;
  logic        irq3;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  logic        got_m;
  logic [31:0] rdv_m;
  int          lat_m;
  logic        seen_m;

  int up_cnt [0:4] = '{0, 1, 2, 3, 0};
  int up_hit [0:4] = '{0, 0, 0, 0, 1};

  always #5 clk = ~clk;

  wb_counter_responder dut (
    .wb_clk_i (clk),    .wb_rst_i (rst),
    .wbs_cyc_i(cyc),    .wbs_stb_i(stb),    .wbs_we_i (we),
    .wbs_sel_i(sel),    .wbs_adr_i(adr),    .wbs_dat_i(dat_i),
    .wbs_ack_o(ack),    .wbs_dat_o(dat_o),
    .io_out   (io_out), .io_oeb   (io_oeb), .irq_o    (irq)
  );

  wb_counter_responder #(.WAIT_STATES(3)) dut3 (
    .wb_clk_i (clk),     .wb_rst_i (rst),
    .wbs_cyc_i(cyc3),    .wbs_stb_i(stb3),    .wbs_we_i (we3),
    .wbs_sel_i(sel3),    .wbs_adr_i(adr3),    .wbs_dat_i(dat3_i),
    .wbs_ack_o(ack3),    .wbs_dat_o(dat3_o),
    .io_out   (io_out3), .io_oeb   (io_oeb3), .irq_o    (irq3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One bus transaction on the main DUT, bounded by max_cyc cycles
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int max_cyc,
                     output logic got, output logic [31:0] rd, output int lat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    got = 1'b0; rd = 32'h0; lat = 0;
    for (int i = 1; i <= max_cyc && !got; i++) begin
      @(negedge clk);
      if (ack) begin
        got = 1'b1; lat = i; rd = dat_o;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s, input string tag);
    logic got; logic [31:0] rdv; int lat;
    bus(1'b1, BASE | 32'(off), d, s, 20, got, rdv, lat);
    check({tag, " ack"}, 32'(got), 32'd1);
    check({tag, " lat"}, 32'(lat), 32'd2);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic got; logic [31:0] rdv; int lat; logic [31:0] e;
    exp_q.push_back(exp);
    bus(1'b0, a, 32'h0, 4'hF, 20, got, rdv, lat);
    check({tag, " ack"}, 32'(got), 32'd1);
    check({tag, " lat"}, 32'(lat), 32'd2);
    e = exp_q.pop_front();
    if (got) check({tag, " data"}, rdv, e);
  endtask

  initial begin
    rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_i = 0;
    cyc3 = 0; stb3 = 0; we3 = 0; sel3 = 0; adr3 = 0; dat3_i = 0;
    repeat (3) @(negedge clk);
    check("rst ack", 32'(ack), 32'd0);
    check("rst dat_o", dat_o, 32'h0);
    check("rst irq", 32'(irq), 32'd0);
    check("rst io_out", 32'(io_out), 32'h0);
    check("rst io_oeb", 32'(io_oeb), 32'hFFFF);
    rst = 1'b0;

    // Reset values through the bus
    rd(BASE + 32'h14, 32'h0000_FFFF, "rd io_oeb");
    rd(BASE + 32'h00, 32'h0, "rd ctrl");
    rd(BASE + 32'h04, 32'h0, "rd count");
    rd(BASE + 32'h08, 32'hFFFF_FFFF, "rd limit");
    rd(BASE + 32'h0C, 32'h0, "rd status");

    // GPIO checkbits and byte enables
    wr(8'h14, 32'h0, 4'hF, "wr oeb");
    @(negedge clk); check("io_oeb 0", 32'(io_oeb), 32'h0);
    wr(8'h10, 32'hAB60, 4'hF, "wr ab60");
    @(negedge clk); check("io_out ab60", 32'(io_out), 32'hAB60);
    wr(8'h10, 32'hAB61, 4'hF, "wr ab61");
    @(negedge clk); check("io_out ab61", 32'(io_out), 32'hAB61);
    wr(8'h10, 32'h1234_5678, 4'b0001, "wr sel1");
    @(negedge clk); check("io_out sel1", 32'(io_out), 32'hAB78);
    wr(8'h10, 32'hFFFF_FFFF, 4'b0000, "wr sel0");
    @(negedge clk); check("io_out sel0", 32'(io_out), 32'hAB78);
    rd(BASE + 32'h10, 32'h0000_AB78, "rd io_out");

    // Up count 0,1,2,3,0 with hit and irq on the wrap
    wr(8'h08, 32'd3, 4'hF, "wr limit3");
    wr(8'h04, 32'd0, 4'hF, "wr count0");
    wr(8'h00, 32'h5, 4'hF, "wr ctrl5");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("up count %0d", i), dut.u_core.count_q, 32'(up_cnt[i]));
      check($sformatf("up hit %0d", i), 32'(dut.u_core.hit_q), 32'(up_hit[i]));
      check($sformatf("up irq %0d", i), 32'(irq), 32'(up_hit[i]));
    end

    // Stop counting, then clear hit with W1C
    wr(8'h00, 32'h4, 4'hF, "wr ctrl4");
    rd(BASE + 32'h0C, 32'h1, "rd status hit");
    check("irq held", 32'(irq), 32'd1);
    wr(8'h0C, 32'h1, 4'hF, "wr w1c");
    @(negedge clk);
    check("w1c hit", 32'(dut.u_core.hit_q), 32'd0);
    check("w1c irq", 32'(irq), 32'd0);
    rd(BASE + 32'h0C, 32'h0, "rd status clr");

    // Hit set beats W1C: LIMIT=0 wraps every cycle
    wr(8'h08, 32'd0, 4'hF, "wr limit0");
    wr(8'h04, 32'd0, 4'hF, "wr count0b");
    wr(8'h00, 32'h5, 4'hF, "wr ctrl5b");
    wr(8'h0C, 32'h1, 4'hF, "wr w1c race");
    @(negedge clk);
    check("w1c race hit", 32'(dut.u_core.hit_q), 32'd1);

    // Down count from 0 reloads LIMIT and sets hit
    wr(8'h00, 32'h0, 4'hF, "wr ctrl0");
    wr(8'h08, 32'd5, 4'hF, "wr limit5");
    wr(8'h04, 32'd0, 4'hF, "wr count0c");
    wr(8'h0C, 32'h1, 4'hF, "wr w1c2");
    rd(BASE + 32'h0C, 32'h0, "rd status dn");
    wr(8'h00, 32'h3, 4'hF, "wr ctrl3");
    @(negedge clk); check("dn count a", dut.u_core.count_q, 32'd0);
    @(negedge clk); check("dn count b", dut.u_core.count_q, 32'd5);
    check("dn hit", 32'(dut.u_core.hit_q), 32'd1);
    @(negedge clk); check("dn count c", dut.u_core.count_q, 32'd4);

    // COUNT write wins over a decrement in the same cycle
    wr(8'h04, 32'h10, 4'hF, "wr count10");
    @(negedge clk); check("load wins", dut.u_core.count_q, 32'h10);
    @(negedge clk); check("load then dec", dut.u_core.count_q, 32'h0F);

    // COUNT byte enables with the counter stopped
    wr(8'h00, 32'h0, 4'hF, "wr ctrl0b");
    wr(8'h04, 32'hAABB_CCDD, 4'hF, "wr count full");
    wr(8'h04, 32'h1122_3344, 4'b0100, "wr count b2");
    rd(BASE + 32'h04, 32'hAA22_CCDD, "rd count sel");

    // Out of window: no ack
    bus(1'b0, BASE + 32'h100, 32'h0, 4'hF, 20, got_m, rdv_m, lat_m);
    check("oow no ack", 32'(got_m), 32'd0);
    // Unmapped in-window offset
    wr(8'h40, 32'hDEAD_BEEF, 4'hF, "wr off40");
    rd(BASE + 32'h40, 32'h0, "rd off40");

    // Abort during WAIT
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = BASE + 32'h10; dat_i = 32'h5555; sel = 4'hF;
    @(negedge clk);
    check("abort wait ack", 32'(ack), 32'd0);
    cyc = 0; stb = 0; we = 0;
    seen_m = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack) seen_m = 1'b1;
    end
    check("abort no ack", 32'(seen_m), 32'd0);
    check("abort io_out", 32'(io_out), 32'hAB78);

    // Reset in the middle of a transaction
    wr(8'h08, 32'd0, 4'hF, "wr limit0b");
    wr(8'h04, 32'd0, 4'hF, "wr count0d");
    wr(8'h00, 32'h5, 4'hF, "wr ctrl5c");
    @(negedge clk);
    check("pre rst irq", 32'(irq), 32'd1);
    cyc = 1; stb = 1; we = 1; adr = BASE + 32'h14; dat_i = 32'h1234; sel = 4'hF;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid rst ack", 32'(ack), 32'd0);
    check("mid rst dat_o", dat_o, 32'h0);
    check("mid rst irq", 32'(irq), 32'd0);
    check("mid rst io_out", 32'(io_out), 32'h0);
    check("mid rst io_oeb", 32'(io_oeb), 32'hFFFF);
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    rst = 1'b0;
    rd(BASE + 32'h14, 32'h0000_FFFF, "post rst oeb");
    rd(BASE + 32'h00, 32'h0, "post rst ctrl");

    // WAIT_STATES=3 build: ack four cycles after stb
    @(negedge clk);
    cyc3 = 1; stb3 = 1; we3 = 0; adr3 = BASE + 32'h14; sel3 = 4'hF;
    got_m = 1'b0; lat_m = 0; rdv_m = 32'h0;
    for (int i = 1; i <= 20 && !got_m; i++) begin
      @(negedge clk);
      if (ack3) begin
        got_m = 1'b1; lat_m = i; rdv_m = dat3_o;
      end
    end
    cyc3 = 0; stb3 = 0;
    check("ws3 ack", 32'(got_m), 32'd1);
    check("ws3 lat", 32'(lat_m), 32'd4);
    check("ws3 data", rdv_m, 32'h0000_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_wb_counter_responder
`default_nettype wire
